vex_lane_sequencer: RTL

VEX_LANE_SEQUENCER -- requirements
Module: vex_lane_sequencer

---
 rtl/vex_lane_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/vex_lane_sequencer.sv
// vex_lane_sequencer
// Executes one 6-lane x 32-bit vector ALU operation from the EX stage by
// time-multiplexing a single shared 32-bit ALU over the lanes, one lane per
// falling clock edge. The upstream pipeline is stalled while the op runs.
//
// Optional feature macro: VEX_SATURATE_EN
//   defined   : add/sub saturate as signed 32-bit; sat_flag is sticky per op
//   undefined : add/sub wrap modulo 2^32; sat_flag is tied to 0
//
// Ports
//   clk            clock, all state updates on the falling edge
//   rst            asynchronous active-low reset
//   in_valid       EX-stage operation present
//   VectorOp_in    operation is a vector op (only these are accepted)
//   ALUOp_in       00 add, 01 sub, 10 mul (low 32 bits), 11 xor
//   RVA_in/RVB_in  operands, 6 lanes x 32 bits, lane 0 = bits 31:0
//   RD_in          destination vector register
//   RegVWrite_in   write-back enable
//   flush          abort the current operation / block acceptance
//   in_ready       ready to accept (IDLE only)
//   stall          hold upstream segments
//   result_out     vector result, held until the next accept
//   result_valid   one-cycle pulse when result_out is complete
//   RD_out         captured destination
//   RegVWrite_out  captured write enable qualified by result_valid
//   sat_flag       at least one lane saturated in the current op
//
// state | meaning
// IDLE  | waiting for a vector op; in_ready=1
// RUN   | one lane computed and written per falling edge
// DONE  | result complete; result_valid=1 for this cycle
module vex_lane_sequencer (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         VectorOp_in,
  input  logic [1:0]   ALUOp_in,
  input  logic [191:0] RVA_in,
  input  logic [191:0] RVB_in,
  input  logic [3:0]   RD_in,
  input  logic         RegVWrite_in,
  input  logic         flush,
  output logic         in_ready,
  output logic         stall,
  output logic [191:0] result_out,
  output logic         result_valid,
  output logic [3:0]   RD_out,
  output logic         RegVWrite_out,
  output logic         sat_flag
);

  localparam int LANES = 6;
  localparam logic [2:0] LAST_LANE = 3'd5;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [2:0]     lane_cnt;
  logic [191:0]   op_a, op_b;
  logic [1:0]     alu_op;
  logic           rvw_q;
  logic           accept;
  logic           lane_step;
  logic [31:0]    lane_a, lane_b, lane_res;
  logic [31:0]    sum, diff, prod;

  assign accept    = (state == IDLE) && in_valid && VectorOp_in && !flush;
  assign lane_step = (state == RUN) && !flush;

  // State register
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; flush wins over everything except reset
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN: begin
        if (flush)                      state_nxt = IDLE;
        else if (lane_cnt == LAST_LANE) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs; a flush seen during DONE suppresses the pulse
  always_comb begin
    in_ready     = (state == IDLE);
    stall        = (state != IDLE) || (in_valid && VectorOp_in);
    result_valid = (state == DONE) && !flush;
  end

  assign RegVWrite_out = rvw_q && result_valid;

  // Lane operand select from the captured operands
  always_comb begin
    lane_a = '0;
    lane_b = '0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_cnt == 3'(k)) begin
        lane_a = op_a[k*32 +: 32];
        lane_b = op_b[k*32 +: 32];
      end
    end
  end

  assign sum  = lane_a + lane_b;
  assign diff = lane_a - lane_b;
  assign prod = lane_a * lane_b;

`ifdef VEX_SATURATE_EN
  logic        add_ovf, sub_ovf, lane_sat, sat_q;
  logic [31:0] sat_val;

  // Signed overflow: result sign differs from what the operand signs allow
  assign add_ovf = (lane_a[31] == lane_b[31]) && (sum[31]  != lane_a[31]);
  assign sub_ovf = (lane_a[31] != lane_b[31]) && (diff[31] != lane_a[31]);
  // Overflow always saturates toward the sign of operand A
  assign sat_val = lane_a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif

  // Shared lane ALU
  always_comb begin
    lane_res = sum;
    case (alu_op)
      2'b00:   lane_res = sum;
      2'b01:   lane_res = diff;
      2'b10:   lane_res = prod;
      default: lane_res = lane_a ^ lane_b;
    endcase
`ifdef VEX_SATURATE_EN
    lane_sat = 1'b0;
    if ((alu_op == 2'b00 && add_ovf) || (alu_op == 2'b01 && sub_ovf)) begin
      lane_res = sat_val;
      lane_sat = 1'b1;
    end
`endif
  end

  // Capture on accept, then write one lane per edge while running
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      op_a       <= '0;
      op_b       <= '0;
      alu_op     <= '0;
      RD_out     <= '0;
      rvw_q      <= 1'b0;
      lane_cnt   <= '0;
      result_out <= '0;
    end else if (accept) begin
      op_a       <= RVA_in;
      op_b       <= RVB_in;
      alu_op     <= ALUOp_in;
      RD_out     <= RD_in;
      rvw_q      <= RegVWrite_in;
      lane_cnt   <= '0;
      result_out <= '0;
    end else if (lane_step) begin
      for (int k = 0; k < LANES; k++) begin
        if (lane_cnt == 3'(k)) result_out[k*32 +: 32] <= lane_res;
      end
      lane_cnt <= (lane_cnt == LAST_LANE) ? 3'd0 : lane_cnt + 3'd1;
    end else if (state == RUN) begin
      lane_cnt <= '0;
    end
  end

`ifdef VEX_SATURATE_EN
  always_ff @(negedge clk or negedge rst) begin
    if (!rst)                       sat_q <= 1'b0;
    else if (accept)                sat_q <= 1'b0;
    else if (lane_step && lane_sat) sat_q <= 1'b1;
  end

  assign sat_flag = sat_q;
`else
  assign sat_flag = 1'b0;
`endif

endmodule
